boxcar_dump: RTL and testbench
==============================

Name: boxcar_dump

Overview:
- Strobed accumulate-and-dump decimator: sums a programmable number of consecutive strobed signed samples, then emits the full-precision sum with a one-cycle output strobe.
- Sits directly upstream of the team's saturating width reducer. Its wide out/strobe_out pair feeds that stage's in/strobe_in unchanged.
- Output width is sized so the sum can never overflow. All range reduction is left to the downstream stage.

Parameters:
- w_in, 16, input sample width (signed two's complement).
- w_cnt, 4, window-length control width; maximum window is 2^w_cnt samples.
- w_out, w_in+w_cnt, output width. Derived; must not be overridden smaller.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  w_in  signed sample, valid when strobe_in=1.
- strobe_in  input  1  sample-valid qualifier; may be high every cycle.
- len  input  w_cnt  window length minus one (window = len+1 samples); sampled only at window start.
- sync  input  1  restart: discard the partial window.
- out  output  w_out  signed window sum; held between dumps.
- strobe_out  output  1  one-cycle pulse: out updated this cycle.
- phase  output  w_cnt  number of samples already in the current window (0 = idle / window start).

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, len_act=0, out=0, strobe_out=0, phase=0.
- Internal state:
  - acc: w_out-bit signed accumulator.
  - cnt: w_cnt-bit sample counter; drives phase.
  - len_act: w_cnt-bit latched window length.
- Cycle with strobe_in=0 and sync=0: acc, cnt and out hold; strobe_out=0.
- strobe_in=1, cnt==0 (window start):
  - len_act <= len.
  - If len==0: out <= sext(in), strobe_out <= 1, cnt stays 0, acc <= 0.
  - Else: acc <= sext(in), cnt <= 1, strobe_out <= 0.
- strobe_in=1, cnt!=0, cnt!=len_act: acc <= acc+sext(in), cnt <= cnt+1.
- strobe_in=1, cnt==len_act (last sample): out <= acc+sext(in), strobe_out <= 1, acc <= 0, cnt <= 0.
- Latency: strobe_out asserts on the clock edge after the last sample's strobe_in cycle, i.e. exactly one register stage. out changes only on that edge.
- Back-to-back windows: with strobe_in continuously high, a new window starts on the cycle right after the last sample. No dead cycle. strobe_out fires every len+1 cycles.
- len changes mid-window are ignored until the next window start.
- sync=1 (priority over accumulation):
  - acc <= 0, cnt <= 0; no strobe_out for the discarded partial window.
  - If strobe_in=1 in the same cycle, that sample is taken as a window start under the cnt==0 rules, with len sampled that cycle. With len==0 it therefore dumps immediately.
  - out holds its previous value.
- Arithmetic: full-precision sign-extended add; no rounding, no saturation.
  - w_out=w_in+w_cnt covers the worst case 2^w_cnt * (-2^(w_in-1)) = -2^(w_out-1) exactly.
- Reset mid-window: partial sum lost; the first strobe after release starts a new window.
- strobe_out is never high for two consecutive cycles unless len_act==0.

Decomposition:
- No shared package is needed. w_out is the only derived constant and lives as a parameter default.
- Single flat module. The counter/compare is too small to justify a sub-module.
- Any wrapper that pairs this block with the downstream saturating reducer instantiates both at top level. No sub-module goes inside this block.

Test Plan:
- len=3, strobes on consecutive cycles with in=1000, 2000, -500, 7 -> one cycle after the 4th strobe: out=2507, strobe_out=1 for exactly one cycle, phase back to 0.
- len=0, in=-5, 12, 32767 on strobes spaced by 2 idle cycles -> out=-5, 12, 32767, each with strobe_out one cycle after its strobe; out held during idle cycles.
- len=15, 16 continuous strobes of in=-32768, then 16 of in=32767 -> out=-524288, then out=524272; no wrap; strobe_out exactly every 16 cycles.
- len=3:
  - After 2 samples (100, 200), assert sync together with strobe in=50.
  - Then 3 more strobes of in=1 -> out=53; no strobe_out for the discarded 300.
- len switched from 3 to 1 after the 2nd sample of a window, samples all 10 -> first dump=40 (old len honoured); following windows dump 20.
- Assert rst_n low mid-window (phase=2, out=77 from a prior window) -> out=0, strobe_out=0, phase=0 immediately (async). After release with len=1, samples 3, 4 -> out=7.

Source files
------------

// File: rtl/boxcar_dump.sv
// boxcar_dump: strobed accumulate-and-dump decimator.
// The output is wide enough that the window sum can never overflow.
module boxcar_dump #(
    parameter int w_in  = 16,
    parameter int w_cnt = 4,
    parameter int w_out = w_in + w_cnt
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_in-1:0]  in,
    input  logic             strobe_in,
    input  logic [w_cnt-1:0] len,
    input  logic             sync,
    output logic [w_out-1:0] out,
    output logic             strobe_out,
    output logic [w_cnt-1:0] phase
);
    logic [w_out-1:0] acc, sx, sum;
    logic [w_cnt-1:0] cnt, len_act;
    logic             start, last;

    // sync restarts the window, so a coincident sample is treated as a window start
    always_comb begin
        sx    = {{(w_out-w_in){in[w_in-1]}}, in};
        start = sync || cnt == '0;
        last  = start ? len == '0 : cnt == len_act;
        sum   = start ? sx : acc + sx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            len_act    <= '0;
            out        <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            if (strobe_in) begin
                if (start) len_act <= len;
                if (last) begin
                    out        <= sum;
                    strobe_out <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= sum;
                    cnt <= start ? w_cnt'(1) : cnt + 1'b1;
                end
            end else if (sync) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

    assign phase = cnt;
endmodule

// File: tb/tb_boxcar_dump.sv
// tb_boxcar_dump: table-driven vectors plus hand sequences; dumps are checked
// against a scoreboard of expected values and due cycles.
module tb_boxcar_dump;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic        strobe_in = 1'b0;
    logic [3:0]  len = '0;
    logic        sync = 1'b0;
    logic [19:0] out;
    logic        strobe_out;
    logic [3:0]  phase;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int val; int due; } exp_t;
    exp_t q[$];

    typedef struct {
        logic s; int v; int l; logic sy;
        bit dump; int exp_out; int exp_phase;
    } vec_t;

    boxcar_dump dut (
        .clk(clk), .rst_n(rst_n), .in(in), .strobe_in(strobe_in), .len(len),
        .sync(sync), .out(out), .strobe_out(strobe_out), .phase(phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe_out must match the head entry on its due cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("dump_missing", 0, q[0].val);
                void'(q.pop_front());
            end
            if (strobe_out) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    chk("unexpected_strobe", $signed(out), 0);
                end else begin
                    chk("dump_value", $signed(out), q[0].val);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic s, input int v, input int l, input logic sy,
                        input bit dump, input int exp);
        strobe_in = s;
        in        = v[15:0];
        len       = l[3:0];
        sync      = sy;
        if (dump) q.push_back('{val: exp, due: cyc + 1});
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
        sync      = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{1'b1,  1000, 3, 1'b0, 1'b0,     0, 1},
            '{1'b1,  2000, 3, 1'b0, 1'b0,     0, 2},
            '{1'b1,  -500, 3, 1'b0, 1'b0,     0, 3},
            '{1'b1,     7, 3, 1'b0, 1'b1,  2507, 0},
            '{1'b0,     0, 3, 1'b0, 1'b0,  2507, 0},
            '{1'b1,    -5, 0, 1'b0, 1'b1,    -5, 0},
            '{1'b0,     0, 0, 1'b0, 1'b0,    -5, 0},
            '{1'b0,     0, 0, 1'b0, 1'b0,    -5, 0},
            '{1'b1,    12, 0, 1'b0, 1'b1,    12, 0},
            '{1'b0,     0, 0, 1'b0, 1'b0,    12, 0},
            '{1'b0,     0, 0, 1'b0, 1'b0,    12, 0},
            '{1'b1, 32767, 0, 1'b0, 1'b1, 32767, 0},
            '{1'b0,     0, 0, 1'b0, 1'b0, 32767, 0}
        };

        #2;
        chk("reset_out", $signed(out), 0);
        chk("reset_strobe", int'(strobe_out), 0);
        chk("reset_phase", int'(phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].sy, tbl[i].dump, tbl[i].exp_out);
            chk($sformatf("vec%0d_out", i), $signed(out), tbl[i].exp_out);
            chk($sformatf("vec%0d_phase", i), int'(phase), tbl[i].exp_phase);
        end

        // Extremes at maximum window length, continuous strobes
        for (int i = 0; i < 16; i++) step(1'b1, -32768, 15, 1'b0, i == 15, -524288);
        chk("max_neg_out", $signed(out), -524288);
        for (int i = 0; i < 16; i++) step(1'b1, 32767, 15, 1'b0, i == 15, 524272);
        chk("max_pos_out", $signed(out), 524272);
        step(1'b0, 0, 15, 1'b0, 1'b0, 0);

        // sync discards the partial window and restarts on its own sample
        step(1'b1, 100, 3, 1'b0, 1'b0, 0);
        step(1'b1, 200, 3, 1'b0, 1'b0, 0);
        step(1'b1, 50, 3, 1'b1, 1'b0, 0);
        chk("sync_phase", int'(phase), 1);
        chk("sync_out_held", $signed(out), 524272);
        step(1'b1, 1, 3, 1'b0, 1'b0, 0);
        step(1'b1, 1, 3, 1'b0, 1'b0, 0);
        step(1'b1, 1, 3, 1'b0, 1'b1, 53);
        chk("sync_out", $signed(out), 53);
        step(1'b0, 0, 3, 1'b0, 1'b0, 0);

        // len change mid-window takes effect at the next window start
        step(1'b1, 10, 3, 1'b0, 1'b0, 0);
        step(1'b1, 10, 3, 1'b0, 1'b0, 0);
        step(1'b1, 10, 1, 1'b0, 1'b0, 0);
        step(1'b1, 10, 1, 1'b0, 1'b1, 40);
        for (int w = 0; w < 2; w++) begin
            step(1'b1, 10, 1, 1'b0, 1'b0, 0);
            step(1'b1, 10, 1, 1'b0, 1'b1, 20);
        end
        chk("len_change_out", $signed(out), 20);
        step(1'b0, 0, 1, 1'b0, 1'b0, 0);

        // Asynchronous reset mid-window
        step(1'b1, 70, 1, 1'b0, 1'b0, 0);
        step(1'b1, 7, 1, 1'b0, 1'b1, 77);
        step(1'b1, 1, 3, 1'b0, 1'b0, 0);
        step(1'b1, 2, 3, 1'b0, 1'b0, 0);
        chk("pre_reset_phase", int'(phase), 2);
        chk("pre_reset_out", $signed(out), 77);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", $signed(out), 0);
        chk("async_reset_strobe", int'(strobe_out), 0);
        chk("async_reset_phase", int'(phase), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 3, 1, 1'b0, 1'b0, 0);
        chk("post_reset_phase", int'(phase), 1);
        step(1'b1, 4, 1, 1'b0, 1'b1, 7);
        chk("post_reset_out", $signed(out), 7);

        repeat (3) step(1'b0, 0, 1, 1'b0, 1'b0, 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
